// File: rtl/ram_sdp_be_if.sv
// ---------------------------------------------------------------------------
// ram_sdp_be_if
// Bus bundle for the simple-dual-port byte-enable RAM.
//
// Signals (master = requester, slave = RAM):
//   clr_req   m->s  1   pulse: start a full-array clear
//   wr_en     m->s  1   write request
//   wr_addr   m->s  AW  write word address
//   wr_data   m->s  DW  write data
//   wr_be     m->s  NB  byte enables, bit i gates wr_data[8i+7:8i]
//   rd_en     m->s  1   read request
//   rd_addr   m->s  AW  read word address
//   rd_data   s->m  DW  read data, meaningful when rd_valid=1, held otherwise
//   rd_valid  s->m  1   one-cycle strobe per completing read
//   busy      s->m  1   clear engine running
//
// Handshake: busy is the inverse of ready. A request (wr_en, rd_en, clr_req)
// is accepted on a rising clk edge if and only if it is high and busy is low
// at that edge; a request seen while busy is high is dropped, not queued.
// rd_valid is a single-cycle strobe with no back-pressure: the master must
// take rd_data in the cycle rd_valid is high.
// ---------------------------------------------------------------------------
interface ram_sdp_be_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   localparam int NB = DW / 8;

   logic          clr_req;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [NB-1:0] wr_be;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          busy;

   modport master (
      output clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      input  rd_data, rd_valid, busy
   );

   modport slave (
      input  clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
      output rd_data, rd_valid, busy
   );
endinterface

// File: rtl/ram_sdp_be.sv
// ---------------------------------------------------------------------------
// ram_sdp_be
// Simple-dual-port RAM (one write port, one read port, one clock) with
// per-byte write enables, 1- or 2-cycle registered read latency, selectable
// read-during-write behaviour and a sequential clear engine that zeroes the
// array one word per cycle after reset or on clr_req.
//
// Parameters:
//   DATA_WIDTH  word width, multiple of 8
//   DEPTH       number of words, any value >= 1
//   RD_LATENCY  1 or 2 cycles from accepted read to rd_valid
//   RDW_MODE    same-address read+write: 0 = old word, 1 = merged new word
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-low reset
//   bus        ram_sdp_be_if slave modport (requests in, read data/busy out)
//   dbg_state  FSM state: 1 = CLEAR, 0 = READY
// ---------------------------------------------------------------------------
module ram_sdp_be #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = 0
) (
   input  logic         clk,
   input  logic         rst,
   ram_sdp_be_if.slave  bus,
   output logic         dbg_state
);
   localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int NB       = DATA_WIDTH / 8;
   localparam int DEPTH_M1 = DEPTH - 1;
   // One extra bit so the range compare is meaningful even when DEPTH == 2**AW.
   localparam logic [AW:0]   DEPTH_W   = DEPTH[AW:0];
   localparam logic [AW-1:0] LAST_ADDR = DEPTH_M1[AW-1:0];

   typedef enum logic {
      READY = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t                state;
   logic [AW-1:0]         clr_addr;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  wr_ok;
   logic                  rd_ok;
   logic                  wr_go;
   logic                  rd_go;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] rd_value;

   assign dbg_state = state;

   // Requests only count in READY; out-of-range writes are dropped and
   // out-of-range reads still complete, returning zero.
   always_comb begin
      wr_ok = ({1'b0, bus.wr_addr} < DEPTH_W);
      rd_ok = ({1'b0, bus.rd_addr} < DEPTH_W);
      wr_go = bus.wr_en && (state == READY) && wr_ok;
      rd_go = bus.rd_en && (state == READY);
   end

   // Read word as seen by the output register. With RDW_MODE=1 a same-address
   // write in this cycle is forwarded byte by byte, giving the post-write word.
   always_comb begin
      rd_word = '0;
      if (rd_ok) begin
         rd_word = mem[bus.rd_addr];
      end
      rd_value = rd_word;
      if ((RDW_MODE == 1) && wr_go && (bus.wr_addr == bus.rd_addr)) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.wr_be[i]) begin
               rd_value[8*i +: 8] = bus.wr_data[8*i +: 8];
            end
         end
      end
   end

   // Clear-engine FSM. CLEAR spends exactly DEPTH edges, one word per edge,
   // and busy is registered alongside the state so it tracks CLEAR exactly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= CLEAR;
         clr_addr <= '0;
         bus.busy <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               if (clr_addr == LAST_ADDR) begin
                  state    <= READY;
                  bus.busy <= 1'b0;
               end else begin
                  clr_addr <= clr_addr + AW'(1);
               end
            end
            READY: begin
               if (bus.clr_req) begin
                  state    <= CLEAR;
                  clr_addr <= '0;
                  bus.busy <= 1'b1;
               end
            end
            default: begin
               state    <= CLEAR;
               clr_addr <= '0;
               bus.busy <= 1'b1;
            end
         endcase
      end
   end

   // Storage has no reset: the clear engine zeroes it after every reset.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[clr_addr] <= '0;
      end else if (wr_go) begin
         for (int i = 0; i < NB; i++) begin
            if (bus.wr_be[i]) begin
               mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
            end
         end
      end
   end

   // Read pipeline. It runs independently of the FSM so reads already
   // accepted when a clear starts still deliver their data.
   if (RD_LATENCY == 2) begin : g_lat2
      logic                  s1_valid;
      logic [DATA_WIDTH-1:0] s1_data;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            s1_valid     <= 1'b0;
            s1_data      <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
         end else begin
            s1_valid     <= rd_go;
            if (rd_go) begin
               s1_data <= rd_value;
            end
            bus.rd_valid <= s1_valid;
            if (s1_valid) begin
               bus.rd_data <= s1_data;
            end
         end
      end
   end else begin : g_lat1
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
         end else begin
            bus.rd_valid <= rd_go;
            if (rd_go) begin
               bus.rd_data <= rd_value;
            end
         end
      end
   end
endmodule
